// File: rtl/l1_rr_arbiter.sv
// l1_rr_arbiter: shares the L1-to-L2 request port among the L1 requesters.
// Optional macro L1_ARB_MMU_PRIORITY_EN gives the MMU requesters (1, 3) strict priority.
module l1_rr_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_W           = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*32-1:0]        req_addr,
    input  logic [NUM_REQ-1:0]           req_rnw,
    input  logic [NUM_REQ*4-1:0]         req_be,
    input  logic [NUM_REQ*32-1:0]        req_wdata,
    input  logic [NUM_REQ*LEN_W-1:0]     req_len,
    output logic                         l2_valid,
    input  logic                         l2_ready,
    output logic [31:0]                  l2_addr,
    output logic                         l2_rnw,
    output logic [3:0]                   l2_be,
    output logic [31:0]                  l2_wdata,
    output logic [LEN_W-1:0]             l2_len,
    output logic [$clog2(NUM_REQ)-1:0]   l2_id,
    input  logic                         l2_rd_valid,
    input  logic [31:0]                  l2_rd_data,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [31:0]                  rsp_data,
    output logic                         rsp_last,
    output logic                         proto_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(MAX_OUTSTANDING);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(MAX_OUTSTANDING);

    logic [IDW-1:0]     ptr_q;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pool;
    logic               stage_free;
    logic               grant_vld;
    logic [IDW-1:0]     gnt_id;
    logic [IDW-1:0]     idx;

    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic [3:0]         sel_be;
    logic [LEN_W-1:0]   sel_len;
    logic               sel_rnw;

    logic               l2_valid_q;
    logic [31:0]        l2_addr_q;
    logic               l2_rnw_q;
    logic [3:0]         l2_be_q;
    logic [31:0]        l2_wdata_q;
    logic [LEN_W-1:0]   l2_len_q;
    logic [IDW-1:0]     l2_id_q;

    logic [IDW-1:0]     fid_q  [MAX_OUTSTANDING];
    logic [LEN_W-1:0]   flen_q [MAX_OUTSTANDING];
    logic [PW-1:0]      wp_q;
    logic [PW-1:0]      rp_q;
    logic [PW:0]        cnt_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               rd_hit;
    logic               head_last;

    logic [LEN_W-1:0]   wcnt_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [31:0]        rsp_data_q;
    logic               rsp_last_q;
    logic               proto_err_q;

    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign stage_free = !l2_valid_q || l2_ready;
    assign elig       = req_valid & (~req_rnw | {NUM_REQ{!fifo_full}});

    // Candidate pool: MMU class wins outright when the priority build is enabled
`ifdef L1_ARB_MMU_PRIORITY_EN
    always_comb begin
        logic [NUM_REQ-1:0] mmu;
        mmu = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mmu[i] = (i == 1) || (i == 3);
        end
        pool = ((elig & mmu) != '0) ? (elig & mmu) : elig;
    end
`else
    always_comb begin
        pool = elig;
    end
`endif

    // Round-robin scan starting at the pointer
    always_comb begin
        grant_vld = 1'b0;
        gnt_id    = ptr_q;
        idx       = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr_q + IDW'(k);
            if (!grant_vld && stage_free && pool[idx]) begin
                grant_vld = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    // Grant vector and mux of the winning request fields
    always_comb begin
        req_ready = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        sel_len   = '0;
        sel_rnw   = 1'b0;
        if (grant_vld) begin
            req_ready[gnt_id] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_addr  = req_addr[i*32 +: 32];
                sel_wdata = req_wdata[i*32 +: 32];
                sel_be    = req_be[i*4 +: 4];
                sel_len   = req_len[i*LEN_W +: LEN_W];
                sel_rnw   = req_rnw[i];
            end
        end
    end

    assign push      = grant_vld && sel_rnw;
    assign rd_hit    = l2_rd_valid && !fifo_empty;
    assign head_last = (wcnt_q == flen_q[rp_q]);
    assign pop       = rd_hit && head_last;

    // Output stage capture and round-robin pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            l2_valid_q <= 1'b0;
            l2_addr_q  <= '0;
            l2_rnw_q   <= 1'b0;
            l2_be_q    <= '0;
            l2_wdata_q <= '0;
            l2_len_q   <= '0;
            l2_id_q    <= '0;
        end else if (grant_vld) begin
            ptr_q      <= gnt_id + IDW'(1);
            l2_valid_q <= 1'b1;
            l2_addr_q  <= sel_addr;
            l2_rnw_q   <= sel_rnw;
            l2_be_q    <= sel_be;
            l2_wdata_q <= sel_wdata;
            l2_len_q   <= sel_rnw ? sel_len : '0;
            l2_id_q    <= gnt_id;
        end else if (l2_ready) begin
            l2_valid_q <= 1'b0;
        end
    end

    // Read-return FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            fid_q[wp_q]  <= gnt_id;
            flen_q[wp_q] <= sel_len;
        end
    end

    // Read-return FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                wp_q <= wp_q + PW'(1);
            end
            if (pop) begin
                rp_q <= rp_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + (PW+1)'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - (PW+1)'(1);
            end
        end
    end

    // Return path: route each word to the head owner, flag orphan words
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            rsp_last_q  <= 1'b0;
            if (rd_hit) begin
                rsp_valid_q[fid_q[rp_q]] <= 1'b1;
                rsp_data_q  <= l2_rd_data;
                rsp_last_q  <= head_last;
                wcnt_q      <= head_last ? '0 : wcnt_q + LEN_W'(1);
            end else if (l2_rd_valid) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign l2_valid  = l2_valid_q;
    assign l2_addr   = l2_addr_q;
    assign l2_rnw    = l2_rnw_q;
    assign l2_be     = l2_be_q;
    assign l2_wdata  = l2_wdata_q;
    assign l2_len    = l2_len_q;
    assign l2_id     = l2_id_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_l1_rr_arbiter.sv
// tb_l1_rr_arbiter: directed vectors for the L1 round-robin arbiter.
// Expected values are hand-computed from the arbitration rules.
module tb_l1_rr_arbiter;

    localparam int N  = 4;
    localparam int LW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_addr;
    logic [N-1:0]    req_rnw;
    logic [N*4-1:0]  req_be;
    logic [N*32-1:0] req_wdata;
    logic [N*LW-1:0] req_len;
    logic            l2_valid;
    logic            l2_ready;
    logic [31:0]     l2_addr;
    logic            l2_rnw;
    logic [3:0]      l2_be;
    logic [31:0]     l2_wdata;
    logic [LW-1:0]   l2_len;
    logic [1:0]      l2_id;
    logic            l2_rd_valid;
    logic [31:0]     l2_rd_data;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic            rsp_last;
    logic            proto_err;

    int total = 0;
    int bad   = 0;

    int          seq   [5];
    logic [31:0] words [4];

    always #5 clk = ~clk;

    l1_rr_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(4), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_rnw(req_rnw), .req_be(req_be),
        .req_wdata(req_wdata), .req_len(req_len),
        .l2_valid(l2_valid), .l2_ready(l2_ready),
        .l2_addr(l2_addr), .l2_rnw(l2_rnw), .l2_be(l2_be),
        .l2_wdata(l2_wdata), .l2_len(l2_len), .l2_id(l2_id),
        .l2_rd_valid(l2_rd_valid), .l2_rd_data(l2_rd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_req(input int i, input logic rnw,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [LW-1:0] len);
        req_rnw[i]            = rnw;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
        req_be[i*4 +: 4]      = 4'hF;
        req_len[i*LW +: LW]   = len;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef L1_ARB_MMU_PRIORITY_EN
        seq = '{1, 3, 1, 3, 1};
`else
        seq = '{0, 1, 2, 3, 0};
`endif
        words = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};

        rst         = 1'b1;
        req_valid   = '0;
        req_rnw     = '0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        req_len     = '0;
        l2_ready    = 1'b1;
        l2_rd_valid = 1'b0;
        l2_rd_data  = '0;
        tick;
        tick;
        settle;
        chk("rst_l2_valid", l2_valid, 0);
        chk("rst_l2_addr", l2_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_req_ready", req_ready, 0);
        rst = 1'b0;

        // round-robin over four writers
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b0, 32'h1000 + 32'(i*4), 32'hD000_0000 + 32'(i), '0);
        end
        req_valid = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            settle;
            chk("rr_ready", req_ready, 64'(1) << seq[s]);
            tick;
            chk("rr_l2_id", l2_id, seq[s]);
            chk("rr_l2_wdata", l2_wdata, 32'hD000_0000 + 32'(seq[s]));
            chk("rr_l2_valid", l2_valid, 1);
        end
        req_valid = '0;
        tick;
        chk("rr_idle", l2_valid, 0);

        // single 4-word burst read from requester 2
        set_req(2, 1'b1, 32'h8000_0010, 32'h0, 5'd3);
        req_valid = 4'b0100;
        settle;
        chk("br_ready", req_ready, 4'b0100);
        tick;
        req_valid = '0;
        chk("br_l2_rnw", l2_rnw, 1);
        chk("br_l2_len", l2_len, 3);
        chk("br_l2_id", l2_id, 2);
        chk("br_l2_addr", l2_addr, 32'h8000_0010);
        tick;
        for (int w = 0; w < 4; w++) begin
            l2_rd_valid = 1'b1;
            l2_rd_data  = words[w];
            tick;
            chk("br_rsp_valid", rsp_valid, 4'b0100);
            chk("br_rsp_data", rsp_data, words[w]);
            chk("br_rsp_last", rsp_last, (w == 3) ? 1 : 0);
        end
        l2_rd_valid = 1'b0;
        tick;
        chk("br_done_valid", rsp_valid, 0);
        chk("br_done_last", rsp_last, 0);

        // orphan word with the FIFO empty
        l2_rd_valid = 1'b1;
        l2_rd_data  = 32'hBAD0_0BAD;
        tick;
        l2_rd_valid = 1'b0;
        chk("orph_err", proto_err, 1);
        chk("orph_rsp", rsp_valid, 0);
        tick;
        chk("orph_sticky", proto_err, 1);

        // fill the FIFO with single-word reads
        set_req(0, 1'b1, 32'h3000, 32'h0, 5'd0);
        req_valid = 4'b0001;
        for (int r = 0; r < 4; r++) begin
            settle;
            chk("full_fill", req_ready, 4'b0001);
            tick;
        end
        settle;
        chk("full_blk", req_ready, 0);
        set_req(1, 1'b0, 32'h3100, 32'h5555_AAAA, 5'd0);
        req_valid = 4'b0011;
        settle;
        chk("full_wr_ok", req_ready, 4'b0010);
        tick;
        chk("full_wr_id", l2_id, 1);
        chk("full_wr_rnw", l2_rnw, 0);
        req_valid   = 4'b0001;
        l2_rd_valid = 1'b1;
        l2_rd_data  = 32'h0000_0011;
        settle;
        chk("full_pop_same", req_ready, 0);
        tick;
        l2_rd_valid = 1'b0;
        chk("full_pop_rsp", rsp_valid, 4'b0001);
        chk("full_pop_last", rsp_last, 1);
        settle;
        chk("full_reopen", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        for (int w = 0; w < 4; w++) begin
            l2_rd_valid = 1'b1;
            l2_rd_data  = 32'h20 + 32'(w);
            tick;
            chk("drain_rsp", rsp_valid, 4'b0001);
            chk("drain_data", rsp_data, 32'h20 + 32'(w));
            chk("drain_last", rsp_last, 1);
        end
        l2_rd_valid = 1'b0;
        tick;

        // output stage stall
        l2_ready = 1'b0;
        set_req(0, 1'b0, 32'h2000, 32'hCAFE_F00D, 5'd0);
        req_valid = 4'b0001;
        settle;
        chk("stall_gnt0", req_ready, 4'b0001);
        tick;
        set_req(1, 1'b0, 32'h2100, 32'h1111_1111, 5'd0);
        set_req(2, 1'b0, 32'h2200, 32'h2222_2222, 5'd0);
        req_valid = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            settle;
            chk("stall_ready", req_ready, 0);
            chk("stall_addr", l2_addr, 32'h2000);
            chk("stall_wdata", l2_wdata, 32'hCAFE_F00D);
            chk("stall_id", l2_id, 0);
            chk("stall_valid", l2_valid, 1);
            tick;
        end
        l2_ready = 1'b1;
        settle;
        chk("stall_resume", req_ready, 4'b0010);
        tick;
        chk("stall_next_id", l2_id, 1);
        req_valid = '0;
        tick;

        // reset in the middle of an 8-word burst
        set_req(3, 1'b1, 32'h4000, 32'h0, 5'd7);
        req_valid = 4'b1000;
        settle;
        chk("mid_gnt", req_ready, 4'b1000);
        tick;
        req_valid = '0;
        tick;
        for (int w = 0; w < 3; w++) begin
            l2_rd_valid = 1'b1;
            l2_rd_data  = 32'h40 + 32'(w);
            tick;
        end
        l2_rd_valid = 1'b0;
        chk("mid_pre_rsp", rsp_valid, 4'b1000);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_l2v", l2_valid, 0);
        chk("mid_rst_addr", l2_addr, 0);
        chk("mid_rst_id", l2_id, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_last", rsp_last, 0);
        chk("mid_rst_err", proto_err, 0);

        // fresh 2-word read after the reset
        set_req(1, 1'b1, 32'h5000, 32'h0, 5'd1);
        req_valid = 4'b0010;
        settle;
        chk("post_gnt", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        tick;
        for (int w = 0; w < 2; w++) begin
            l2_rd_valid = 1'b1;
            l2_rd_data  = 32'h50 + 32'(w);
            tick;
            chk("post_rsp", rsp_valid, 4'b0010);
            chk("post_data", rsp_data, 32'h50 + 32'(w));
            chk("post_last", rsp_last, (w == 1) ? 1 : 0);
        end
        l2_rd_valid = 1'b0;
        tick;
        chk("post_idle", rsp_valid, 0);
        chk("post_err", proto_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l1_rr_arbiter.md
Name: l1_rr_arbiter

Overview:
- Shares the single L1-to-L2 memory request port among the L1 requesters: dcache, dmmu, icache and immu (IDs 0..3).
- Round-robin grant into a registered output stage.
- Tracks outstanding reads in an in-order ID FIFO so that returning read words, including bursts, are routed back to the originating requester.
- Sits between the L1 units and the bus/L2 adapter.

Parameters:
- NUM_REQ, 4, number of requesters; power of two; requester i = L1 connection ID i.
- MAX_OUTSTANDING, 4, read-return FIFO depth; power of two.
- LEN_W, 5, burst length field width; a length code encodes (words - 1).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero
- req_addr  in  NUM_REQ*32  word-aligned address, requester i at bits [32i+:32]
- req_rnw  in  NUM_REQ  1 = read, 0 = write
- req_be  in  NUM_REQ*4  write byte enables
- req_wdata  in  NUM_REQ*32  write data
- req_len  in  NUM_REQ*LEN_W  read burst length - 1; ignored for writes (always single word)
- l2_valid  out  1  output-stage request valid
- l2_ready  in  1  L2 accepts the output-stage request
- l2_addr  out  32, l2_rnw out 1, l2_be out 4, l2_wdata out 32, l2_len out LEN_W  registered copy of the granted request
- l2_id  out  $clog2(NUM_REQ)  granted requester ID
- l2_rd_valid  in  1  read data word valid; returns in request order; no backpressure
- l2_rd_data  in  32  read data word
- rsp_valid  out  NUM_REQ  one-hot read-data valid to the owning requester
- rsp_data  out  32  read data, shared by all requesters
- rsp_last  out  1  final word of the burst
- proto_err  out  1  sticky: read word arrived with no outstanding read

Behaviour:
- Reset clears all outputs to 0, the round-robin pointer to 0, the FIFO to empty, the word counter to 0 and proto_err to 0. Reset mid-burst discards all outstanding state.
- Output stage is free when `!l2_valid || l2_ready`.
- Eligibility: requester i is eligible when `req_valid[i] && (!req_rnw[i] || !fifo_full)`.
  - A full FIFO blocks reads only; writes still proceed.
  - A pop in the same cycle does NOT unblock reads.
- Grant:
  - When the output stage is free, grant the first eligible requester scanning from ptr, ptr+1, ... mod NUM_REQ.
  - req_ready[g] is asserted combinationally in that cycle; the request is captured into the l2_* registers on that edge.
  - After a grant, ptr <= (g+1) mod NUM_REQ. The pointer is unchanged when nothing is granted.
- The output stage holds stable while `l2_valid && !l2_ready`. Back-to-back grants occur on consecutive cycles when l2_ready stays high, giving one request per cycle.
- A granted read pushes {g, len} into the FIFO on the capture edge, so the FIFO entry exists before any data can return.
- Return path:
  - When l2_rd_valid and the FIFO is non-empty, then on the next cycle: rsp_valid[head.id]=1 and rsp_data=l2_rd_data (1-cycle registered latency).
  - The word counter increments per word. When the counter equals head.len: rsp_last=1, pop the FIFO, clear the counter.
  - When l2_rd_valid and the FIFO is empty: drop the word, set proto_err (sticky until rst), keep rsp_valid at 0.
- Simultaneous push and pop are allowed; the occupancy count is unchanged. Pointer wrap is modulo FIFO depth.
- A write issues no response.

Optional Feature:
- Macro: L1_ARB_MMU_PRIORITY_EN.
- Defined: requesters 1 (dmmu) and 3 (immu) take strict priority over 0 and 2. Between 1 and 3, and among 0/2, the round-robin pointer order still applies. The pointer updates only on grants to the winning class's members.
- Undefined: pure round-robin across all NUM_REQ.

Test Plan:
- Reset, then req_valid=4'b1111, all writes, l2_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles; l2_id follows the same sequence; ptr wraps.
- Requester 2 issues a read, len=3, addr 0x80000010, followed by 4 l2_rd_valid words A..D -> rsp_valid=4'b0100 for 4 cycles, each 1 cycle after the matching input; rsp_last only with D; FIFO empty afterwards.
- Five reads issued with no data returned (MAX_OUTSTANDING=4) -> 4 granted; 5th req_ready=0; a concurrent write from requester 1 is still granted; the 5th read is granted the cycle after the first pop completes.
- l2_ready=0 for 3 cycles with a write pending from requester 0 -> l2_addr/l2_wdata/l2_id stable; no other req_ready is asserted; grant resumes when l2_ready=1.
- l2_rd_valid pulse with no outstanding read -> proto_err=1 and stays 1; rsp_valid=0. Assert rst mid-burst (len=7, 3 words returned) -> all outputs 0 next cycle; the next read completes normally.
- With L1_ARB_MMU_PRIORITY_EN, req_valid=4'b1111 continuously -> grants alternate 1,3,1,3; 0 and 2 are never granted. Without the macro -> 0,1,2,3.
